// File: rtl/odo_sbox_small_seq.sv
// ---------------------------------------------------------------------------
// odo_sbox_small_seq
//   Upstream sequencer for the 6-bit small S-box ROM. It takes one DATA_W-bit
//   word and splits it into NCHUNK chunks of CHUNK_W bits. The chunks are
//   streamed through a single shared ROM port, one per cycle, with chunk 0
//   (the LSBs) going first. The substituted word is reassembled from the
//   results. The ROM has a registered output, so each result arrives one
//   cycle after its address.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        input word valid
//   in_ready   out  1        block can accept a word this cycle
//   in_data    in   DATA_W   word to substitute (chunk i = in_data[i*6 +: 6])
//   sbox_addr  out  CHUNK_W  ROM address
//   sbox_data  in   CHUNK_W  ROM registered output
//   out_valid  out  1        substituted word valid
//   out_ready  in   1        consumer accepts the word
//   out_data   out  DATA_W   substituted word (chunk i = ROM[in chunk i])
// ---------------------------------------------------------------------------
module odo_sbox_small_seq #(
    parameter int CHUNK_W = 6,
    parameter int NCHUNK  = 10,
    parameter int DATA_W  = 60
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic [CHUNK_W-1:0]  sbox_addr,
    input  logic [CHUNK_W-1:0]  sbox_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data
);

    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   srcWord_q;
    logic [DATA_W-1:0]   resWord_q, resWord_d;
    logic [DATA_W-1:0]   outData_q;
    logic                outValid_q;
    logic                capEn_q;
    logic [IDX_W-1:0]    capIdx_q;
    logic                accept;

    assign accept    = in_valid & in_ready;
    assign out_valid = outValid_q;
    assign out_data  = outData_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. IDLE always has in_ready high, so in_valid alone
    // starts a word there. DONE hands straight over to a new word when the
    // consumer takes the result and a new word is waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ISSUE;
            ISSUE:   if (idx_q == LAST_IDX) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (out_ready) state_d = in_valid ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. The ROM address is combinational from the latched source
    // word, so the ROM registers chunk idx on the same edge that idx
    // advances. Outside ISSUE the address is parked at zero.
    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        sbox_addr = '0;
        if (state_q == ISSUE) begin
            for (int i = 0; i < NCHUNK; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    sbox_addr = srcWord_q[i*CHUNK_W +: CHUNK_W];
                end
            end
        end
    end

    // Chunk counter. It restarts on acceptance and stops at the last chunk
    // instead of wrapping.
    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            idx_d = '0;
        end else if ((state_q == ISSUE) && (idx_q != LAST_IDX)) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // Result assembly. capEn/capIdx trail the issue side by one cycle to
    // match the ROM latency, and they drop the returning chunk into its slot.
    always_comb begin
        resWord_d = resWord_q;
        if (capEn_q) begin
            for (int i = 0; i < NCHUNK; i++) begin
                if (capIdx_q == IDX_W'(i)) begin
                    resWord_d[i*CHUNK_W +: CHUNK_W] = sbox_data;
                end
            end
        end
    end

    // Datapath registers. out_data loads from resWord_d, not resWord_q. The
    // last chunk arrives on the same edge as DRAIN->DONE, so it must be
    // folded in without waiting one more cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            srcWord_q  <= '0;
            resWord_q  <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            capEn_q    <= 1'b0;
            capIdx_q   <= '0;
        end else begin
            idx_q     <= idx_d;
            resWord_q <= resWord_d;
            capEn_q   <= (state_q == ISSUE);
            capIdx_q  <= idx_q;
            if (accept) begin
                srcWord_q <= in_data;
            end
            if (state_q == DRAIN) begin
                outData_q  <= resWord_d;
                outValid_q <= 1'b1;
            end else if ((state_q == DONE) && out_ready) begin
                outValid_q <= 1'b0;
            end
        end
    end

endmodule
